output_port_scheduler: RTL and testbench
========================================

# output_port_scheduler

Round-robin scheduler and single-entry output register that shares one router output link among five requesters: the North, South, East and West incoming port handlers and the cache read-return path. It sits between the per-port forwarding decisions and the outgoing link. Each cycle it grants at most one requester, registers that requester's packet, and holds the packet until the downstream link accepts it. It also flags any requester that has waited too long under backpressure.

## Interface
Parameters:
- STARVE_LIMIT, 64: number of consecutive ungranted request cycles that sets `starveFlag`; legal range 1..255.
- Field widths come from `globalVariables.v`:
  - ADDR_W = `NETWORK_ADDRESS_WIDTH` + `CACHE_BANK_ADDRESS_WIDTH`
  - NET_W = `NETWORK_ADDRESS_WIDTH`
  - DATA_W = `DATA_WIDTH`

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- req  in  5  request vector {CACHE,WEST,EAST,SOUTH,NORTH}; bit 0 = NORTH.
- destinationAddressIn_X  in  ADDR_W  destination address, per X ∈ {NORTH,SOUTH,EAST,WEST}.
- requesterAddressIn_X  in  NET_W  requester address, per X.
- readIn_X, writeIn_X  in  1  packet type flags, per X.
- dataIn_X  in  DATA_W  packet payload, per X.
- readRequesterAddress  in  NET_W  cache return target.
- cacheDataOut  in  DATA_W  cache return data.
- grant  out  5  one-hot; combinational; the requester's packet is captured at this rising edge.
- outReady  in  1  downstream link accepts the current output this cycle.
- outValid  out  1  output register holds a packet.
- destinationAddressOut  out  ADDR_W  registered destination address.
- requesterAddressOut  out  NET_W  registered requester address.
- readOut, writeOut  out  1  registered packet type flags.
- dataOut  out  DATA_W  registered payload.
- starveFlag  out  1  sticky; some requester waited STARVE_LIMIT cycles.

## Operation
- slotFree = ~outValid | outReady.
- Winner selection:
  - Scan req starting at index ptr (3-bit, values 0..4), upward, wrapping 4→0.
  - The first set bit is the winner.
  - grant[winner] = slotFree & req[winner]; every other grant bit is 0.
  - grant = 0 whenever slotFree = 0, req = 0, or reset is asserted.
- Requester obligation: hold req and its payload stable until granted. Deasserting req before grant is permitted; the request is dropped with no side effects.
- On an edge where some grant bit is set:
  - The output register loads the winner's payload.
  - outValid <= 1.
  - ptr <= (winner == 4) ? 0 : winner+1.
- Cache payload mapping:
  - destinationAddressOut = {readRequesterAddress, zeros of width `CACHE_BANK_ADDRESS_WIDTH`}.
  - requesterAddressOut = readRequesterAddress.
  - readOut = 1, writeOut = 0, dataOut = cacheDataOut.
- slotFree = 1 and req = 0: outValid <= 0 and readOut/writeOut <= 0; address and data registers hold.
- slotFree = 0 (outValid = 1, outReady = 0): all output registers and ptr hold.
- Simultaneous events: when outReady and a new grant occur on the same edge, the old packet is consumed and the new one is loaded back-to-back with no bubble.
- Wait counters:
  - One 8-bit counter per requester.
  - Increment when req[i] & ~grant[i]; saturate at 255.
  - Clear to 0 when grant[i] or ~req[i].
- starveFlag:
  - Set at the edge where any counter increments to ≥ STARVE_LIMIT.
  - Cleared only by reset.
  - Without backpressure, the maximum wait is 4 cycles.

## Timing
- Reset values:
  - outValid = 0, readOut = 0, writeOut = 0.
  - destinationAddressOut = 0, requesterAddressOut = 0, dataOut = 0.
  - starveFlag = 0, ptr = 0, all wait counters = 0.
- Reset behaviour:
  - Reset assertion clears all of the above immediately, with no clock required.
  - A packet held in the output register at the moment of reset is discarded.
  - Deassertion takes effect at the first rising edge after reset returns to 1.
- Latency: grant in cycle N → packet visible on the outputs (outValid = 1) from cycle N+1.
- Throughput: one packet per cycle while outReady = 1.
- Downstream handshake: the packet transfers on each edge with outValid & outReady.

## Test plan
- Single requester: reset release, req = 5'b00100 with dataIn_EAST = 'hA5 for one cycle → grant = 5'b00100 that cycle; next cycle outValid = 1, dataOut = 'hA5; ptr = 3.
- All requesters: req = 5'b11111 held, outReady = 1 → grants NORTH, SOUTH, EAST, WEST, CACHE, NORTH in consecutive cycles; ptr wraps 4→0; outValid stays 1.
- Backpressure: outValid = 1, outReady = 0 for 10 cycles with req = 5'b00011 → grant = 0 and outputs stable throughout; on outReady = 1, grant appears on the same cycle.
- Cache path: req = 5'b10000, readRequesterAddress = 3 → next cycle requesterAddressOut = 3, destination upper field = 3, bank field = 0, readOut = 1, writeOut = 0.
- Starvation: STARVE_LIMIT = 4, outReady = 0 with outValid = 1, req[1] held → starveFlag rises at the 4th waiting edge and stays 1 after the request is granted.
- Mid-operation reset: pulse reset low between edges while outValid = 1 → outputs and starveFlag clear immediately; first grant after release goes to the lowest set req bit (ptr = 0).

Source files
------------

// File: rtl/output_port_scheduler_if.sv
// Link-arbiter bus: five requester payloads in, one registered packet out.
// The master modport drives requests and outReady; the slave modport is the scheduler.
interface output_port_scheduler_if #(
  parameter int unsigned NET_W  = 4,
  parameter int unsigned BANK_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned ADDR_W = NET_W + BANK_W;

  logic [4:0]        req;
  logic [4:0]        grant;

  logic [ADDR_W-1:0] destinationAddressIn_NORTH, destinationAddressIn_SOUTH;
  logic [ADDR_W-1:0] destinationAddressIn_EAST,  destinationAddressIn_WEST;
  logic [NET_W-1:0]  requesterAddressIn_NORTH,   requesterAddressIn_SOUTH;
  logic [NET_W-1:0]  requesterAddressIn_EAST,    requesterAddressIn_WEST;
  logic              readIn_NORTH, readIn_SOUTH, readIn_EAST, readIn_WEST;
  logic              writeIn_NORTH, writeIn_SOUTH, writeIn_EAST, writeIn_WEST;
  logic [DATA_W-1:0] dataIn_NORTH, dataIn_SOUTH, dataIn_EAST, dataIn_WEST;

  logic [NET_W-1:0]  readRequesterAddress;
  logic [DATA_W-1:0] cacheDataOut;

  logic              outReady;
  logic              outValid;
  logic [ADDR_W-1:0] destinationAddressOut;
  logic [NET_W-1:0]  requesterAddressOut;
  logic              readOut;
  logic              writeOut;
  logic [DATA_W-1:0] dataOut;
  logic              starveFlag;

  modport master (
    output req, outReady, readRequesterAddress, cacheDataOut,
    output destinationAddressIn_NORTH, destinationAddressIn_SOUTH,
    output destinationAddressIn_EAST,  destinationAddressIn_WEST,
    output requesterAddressIn_NORTH, requesterAddressIn_SOUTH,
    output requesterAddressIn_EAST,  requesterAddressIn_WEST,
    output readIn_NORTH, readIn_SOUTH, readIn_EAST, readIn_WEST,
    output writeIn_NORTH, writeIn_SOUTH, writeIn_EAST, writeIn_WEST,
    output dataIn_NORTH, dataIn_SOUTH, dataIn_EAST, dataIn_WEST,
    input  grant, outValid, destinationAddressOut, requesterAddressOut,
    input  readOut, writeOut, dataOut, starveFlag
  );

  modport slave (
    input  req, outReady, readRequesterAddress, cacheDataOut,
    input  destinationAddressIn_NORTH, destinationAddressIn_SOUTH,
    input  destinationAddressIn_EAST,  destinationAddressIn_WEST,
    input  requesterAddressIn_NORTH, requesterAddressIn_SOUTH,
    input  requesterAddressIn_EAST,  requesterAddressIn_WEST,
    input  readIn_NORTH, readIn_SOUTH, readIn_EAST, readIn_WEST,
    input  writeIn_NORTH, writeIn_SOUTH, writeIn_EAST, writeIn_WEST,
    input  dataIn_NORTH, dataIn_SOUTH, dataIn_EAST, dataIn_WEST,
    output grant, outValid, destinationAddressOut, requesterAddressOut,
    output readOut, writeOut, dataOut, starveFlag
  );
endinterface

// File: rtl/output_port_scheduler.sv
// Round-robin arbiter for one router output link with a single-entry output
// register, per-requester wait counters and a sticky starvation flag.
module output_port_scheduler #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned NET_W        = 4,
  parameter int unsigned BANK_W       = 4,
  parameter int unsigned DATA_W       = 32
) (
  input logic                    clk,
  input logic                    reset,
  output_port_scheduler_if.slave bus
);
  localparam int unsigned ADDR_W    = NET_W + BANK_W;
  localparam int unsigned N_REQ     = 5;
  localparam int unsigned CACHE_IDX = 4;
  localparam int unsigned CNT_W     = 8;

  logic [2:0]        r_ptr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_dst;
  logic [NET_W-1:0]  r_src;
  logic              r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_data;
  logic              r_starve;
  logic [CNT_W-1:0]  r_wait [N_REQ];

  logic              w_slot_free;
  logic              w_found;
  logic [2:0]        w_win;
  logic [3:0]        w_sum;
  logic [N_REQ-1:0]  w_grant;
  logic [CNT_W-1:0]  w_wait_nxt [N_REQ];
  logic [N_REQ-1:0]  w_hit;

  logic [ADDR_W-1:0] w_dst  [N_REQ];
  logic [NET_W-1:0]  w_src  [N_REQ];
  logic [N_REQ-1:0]  w_rd;
  logic [N_REQ-1:0]  w_wr;
  logic [DATA_W-1:0] w_data [N_REQ];

  // Per-requester payload view; the cache return always targets the requester's bank 0.
  assign w_dst[0] = bus.destinationAddressIn_NORTH;
  assign w_dst[1] = bus.destinationAddressIn_SOUTH;
  assign w_dst[2] = bus.destinationAddressIn_EAST;
  assign w_dst[3] = bus.destinationAddressIn_WEST;
  assign w_dst[4] = {bus.readRequesterAddress, BANK_W'(0)};
  assign w_src[0] = bus.requesterAddressIn_NORTH;
  assign w_src[1] = bus.requesterAddressIn_SOUTH;
  assign w_src[2] = bus.requesterAddressIn_EAST;
  assign w_src[3] = bus.requesterAddressIn_WEST;
  assign w_src[4] = bus.readRequesterAddress;
  assign w_rd     = {1'b1, bus.readIn_WEST, bus.readIn_EAST, bus.readIn_SOUTH, bus.readIn_NORTH};
  assign w_wr     = {1'b0, bus.writeIn_WEST, bus.writeIn_EAST, bus.writeIn_SOUTH, bus.writeIn_NORTH};
  assign w_data[0] = bus.dataIn_NORTH;
  assign w_data[1] = bus.dataIn_SOUTH;
  assign w_data[2] = bus.dataIn_EAST;
  assign w_data[3] = bus.dataIn_WEST;
  assign w_data[4] = bus.cacheDataOut;

  assign w_slot_free = ~r_valid | bus.outReady;

  // First set request at or after r_ptr, wrapping 4 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_sum   = 4'd0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_sum = 4'(r_ptr) + 4'(k);
      if (w_sum >= 4'(N_REQ)) w_sum = w_sum - 4'(N_REQ);
      if (!w_found && bus.req[w_sum[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[2:0];
      end
    end
  end

  assign w_grant = (reset && w_slot_free && w_found) ? N_REQ'(N_REQ'(1) << w_win) : '0;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_wait_nxt[i] = '0;
      if (bus.req[i] && !w_grant[i]) begin
        w_wait_nxt[i] = (r_wait[i] == '1) ? r_wait[i] : r_wait[i] + CNT_W'(1);
        w_hit[i]      = (w_wait_nxt[i] >= CNT_W'(STARVE_LIMIT));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_dst    <= '0;
      r_src    <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_starve <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) r_wait[i] <= '0;
    end else begin
      if (|w_grant) begin
        r_valid <= 1'b1;
        r_dst   <= w_dst[w_win];
        r_src   <= w_src[w_win];
        r_rd    <= w_rd[w_win];
        r_wr    <= w_wr[w_win];
        r_data  <= w_data[w_win];
        r_ptr   <= (w_win == 3'(CACHE_IDX)) ? 3'd0 : w_win + 3'd1;
      end else if (w_slot_free) begin
        // Idle link: drop the valid and type flags, keep address/data as last sent.
        r_valid <= 1'b0;
        r_rd    <= 1'b0;
        r_wr    <= 1'b0;
      end
      if (|w_hit) r_starve <= 1'b1;
      for (int i = 0; i < int'(N_REQ); i++) r_wait[i] <= w_wait_nxt[i];
    end
  end

  assign bus.grant                 = w_grant;
  assign bus.outValid              = r_valid;
  assign bus.destinationAddressOut = r_dst;
  assign bus.requesterAddressOut   = r_src;
  assign bus.readOut               = r_rd;
  assign bus.writeOut              = r_wr;
  assign bus.dataOut               = r_data;
  assign bus.starveFlag            = r_starve;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: expected packets go into a
// scoreboard queue at grant time and are popped when the output register loads.
module tb_output_port_scheduler;
  localparam int unsigned NET_W  = 4;
  localparam int unsigned BANK_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = NET_W + BANK_W;
  localparam int unsigned LIMIT  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [NET_W-1:0]  src;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_port_scheduler_if #(.NET_W(NET_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) bus ();

  output_port_scheduler #(
    .STARVE_LIMIT(LIMIT), .NET_W(NET_W), .BANK_W(BANK_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pkt_t pay [5];
  pkt_t sb_q [$];
  pkt_t m_out;
  logic m_valid;
  int   m_ptr;
  int   m_wait [5];
  logic m_starve;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_grant(input logic [4:0] r, input int p, input logic sf);
    for (int k = 0; k < 5; k++) begin
      int j;
      j = (p + k) % 5;
      if (r[j]) return sf ? 5'(5'd1 << j) : 5'd0;
    end
    return 5'd0;
  endfunction

  task automatic set_cache(input logic [NET_W-1:0] rra, input logic [DATA_W-1:0] d);
    pay[4] = '{dst: {rra, BANK_W'(0)}, src: rra, rd: 1'b1, wr: 1'b0, data: d};
  endtask

  task automatic drive(input logic [4:0] r, input logic ordy);
    bus.req = r;
    bus.outReady = ordy;
    bus.destinationAddressIn_NORTH = pay[0].dst; bus.requesterAddressIn_NORTH = pay[0].src;
    bus.readIn_NORTH = pay[0].rd; bus.writeIn_NORTH = pay[0].wr; bus.dataIn_NORTH = pay[0].data;
    bus.destinationAddressIn_SOUTH = pay[1].dst; bus.requesterAddressIn_SOUTH = pay[1].src;
    bus.readIn_SOUTH = pay[1].rd; bus.writeIn_SOUTH = pay[1].wr; bus.dataIn_SOUTH = pay[1].data;
    bus.destinationAddressIn_EAST = pay[2].dst; bus.requesterAddressIn_EAST = pay[2].src;
    bus.readIn_EAST = pay[2].rd; bus.writeIn_EAST = pay[2].wr; bus.dataIn_EAST = pay[2].data;
    bus.destinationAddressIn_WEST = pay[3].dst; bus.requesterAddressIn_WEST = pay[3].src;
    bus.readIn_WEST = pay[3].rd; bus.writeIn_WEST = pay[3].wr; bus.dataIn_WEST = pay[3].data;
    bus.readRequesterAddress = pay[4].src;
    bus.cacheDataOut = pay[4].data;
  endtask

  task automatic check_outputs();
    chk("outValid",   32'(bus.outValid), 32'(m_valid));
    chk("destAddr",   32'(bus.destinationAddressOut), 32'(m_out.dst));
    chk("reqAddr",    32'(bus.requesterAddressOut), 32'(m_out.src));
    chk("readOut",    32'(bus.readOut), 32'(m_out.rd));
    chk("writeOut",   32'(bus.writeOut), 32'(m_out.wr));
    chk("dataOut",    32'(bus.dataOut), 32'(m_out.data));
    chk("starveFlag", 32'(bus.starveFlag), 32'(m_starve));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_out = '0; m_ptr = 0; m_starve = 1'b0;
    for (int i = 0; i < 5; i++) m_wait[i] = 0;
    sb_q.delete();
  endtask

  // One clock: drive at posedge+1, check grant, then check registered outputs after the edge.
  task automatic cycle(input logic [4:0] r, input logic ordy);
    logic [4:0] eg;
    logic       sf;
    drive(r, ordy);
    #1;
    sf = !m_valid || ordy;
    eg = exp_grant(r, m_ptr, sf);
    chk("grant", 32'(bus.grant), 32'(eg));
    for (int i = 0; i < 5; i++) begin
      if (r[i] && !eg[i]) begin
        if (m_wait[i] < 255) m_wait[i]++;
        if (m_wait[i] >= int'(LIMIT)) m_starve = 1'b1;
      end else begin
        m_wait[i] = 0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (eg[i]) begin
        sb_q.push_back(pay[i]);
        m_ptr = (i == 4) ? 0 : i + 1;
      end
    end
    @(posedge clk);
    #1;
    if (eg != 5'd0) begin
      m_out = sb_q.pop_front();
      m_valid = 1'b1;
    end else if (sf) begin
      m_valid = 1'b0;
      m_out.rd = 1'b0;
      m_out.wr = 1'b0;
    end
    check_outputs();
  endtask

  // Asynchronous reset pulse between edges; clears must be visible before any clock.
  task automatic mid_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    check_outputs();
    drive(5'd0, 1'b1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    pay[0] = '{dst: 8'h21, src: 4'h1, rd: 1'b1, wr: 1'b0, data: 16'h1111};
    pay[1] = '{dst: 8'h32, src: 4'h2, rd: 1'b0, wr: 1'b1, data: 16'h2222};
    pay[2] = '{dst: 8'h43, src: 4'h3, rd: 1'b1, wr: 1'b0, data: 16'h00A5};
    pay[3] = '{dst: 8'h54, src: 4'h4, rd: 1'b0, wr: 1'b1, data: 16'h4444};
    set_cache(4'h3, 16'hCAFE);
    model_reset();
    drive(5'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    check_outputs();
    reset = 1'b1;

    // Single EAST request, then backpressure with NORTH/SOUTH waiting long enough to starve.
    cycle(5'b00100, 1'b0);
    chk("east_data", 32'(bus.dataOut), 32'h00A5);
    repeat (10) cycle(5'b00011, 1'b0);
    chk("starved", 32'(bus.starveFlag), 32'd1);
    cycle(5'b00011, 1'b1);
    cycle(5'b00010, 1'b1);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b0);

    // WEST load, NORTH drops its request before being served, then cache return.
    cycle(5'b01000, 1'b1);
    cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);
    cycle(5'b10000, 1'b1);
    chk("cache_dst", 32'(bus.destinationAddressOut), 32'h30);
    chk("cache_rd",  32'(bus.readOut), 32'd1);

    mid_reset();

    // All five requesting with a free link: N,S,E,W,C,N.
    repeat (6) cycle(5'b11111, 1'b1);
    pay[1].data = 16'h5A5A;
    cycle(5'b00010, 1'b1);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
